// File: rtl/time_align_out_buffer.sv
// time_align_out_buffer
// ---------------------
// Downstream stage of the two-stage time aligner. A sample-valid strobe is
// regenerated by delaying msb_valid_i by the aligner latency. Each aligned word
// is pushed into a first-word-fall-through FIFO, and the FIFO drains toward the
// sink. Words that arrive while the FIFO is full and not popping are dropped.
// Drops set a sticky flag and advance a saturating counter.
//
// Ports
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset
//   msb_valid_i  : a new msb sample enters the aligner this cycle
//   din_i        : aligner output word {msb[2:0], lsb[2:0]}
//   clear_i      : synchronous clear of overflow_o / drop_cnt_o
//   m_valid_o    : head word available
//   m_ready_i    : sink accepts head word
//   m_data_o     : head word (zero while empty)
//   count_o      : occupancy, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   overflow_o   : sticky, a word was dropped
//   drop_cnt_o   : number of dropped words, saturating
//
// Handshake: a word transfers on every rising edge where m_valid_o and
// m_ready_i are both high. While m_valid_o=1 and m_ready_i=0, m_data_o is held
// stable. m_ready_i has no effect while m_valid_o=0. m_valid_o does not depend
// on m_ready_i.
module time_align_out_buffer #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int ALIGN_LAT = 1,
  parameter int CNT_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       msb_valid_i,
  input  logic [DATA_W-1:0]          din_i,
  input  logic                       clear_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DATA_W-1:0]          m_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              w_aligned_vld;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  // Valid delay line matching the aligner latency; zero latency is a wire.
  if (ALIGN_LAT == 0) begin : g_no_dly
    assign w_aligned_vld = msb_valid_i;
  end else begin : g_dly
    logic [ALIGN_LAT-1:0] r_vld_dly;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_vld_dly <= '0;
      end else begin
        r_vld_dly[0] <= msb_valid_i;
        for (int i = 1; i < ALIGN_LAT; i++) begin
          r_vld_dly[i] <= r_vld_dly[i-1];
        end
      end
    end
    assign w_aligned_vld = r_vld_dly[ALIGN_LAT-1];
  end

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && m_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push  = w_aligned_vld && (!w_full || w_pop);
  assign w_drop  = w_aligned_vld && w_full && !w_pop;

  // Storage is not reset; the empty mask on m_data_o covers stale contents.
  always_ff @(posedge clk_i) begin
    if (w_push && !reset_i) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as clear_i wins over the clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_overflow <= w_drop;
      r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign m_valid_o  = !w_empty;
  assign m_data_o   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_time_align_out_buffer.sv
// Testbench for time_align_out_buffer: randomized traffic against a queue-based
// reference model of the aligned FIFO, plus the directed scenarios.
module tb_time_align_out_buffer;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int LAT    = 1;
  localparam int CNT_W  = 8;

  logic              clk_i;
  logic              reset_i;
  logic              msb_valid_i;
  logic [DATA_W-1:0] din_i;
  logic              clear_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic [3:0]        count_o;
  logic              full_o;
  logic              empty_o;
  logic              overflow_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  time_align_out_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ALIGN_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .msb_valid_i(msb_valid_i),
    .din_i(din_i), .clear_i(clear_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  // clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                cyc = 0;
  int                last_rst = -1000;
  bit                hist[int];
  logic [DATA_W-1:0] din_by_cycle[int];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] popped_q[$];
  bit                exp_ovf = 1'b0;
  int                exp_drops = 0;

  function automatic bit exp_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_head();
    if (exp_q.size() == 0) return '0;
    return exp_q[0];
  endfunction

  // Drive one cycle of inputs, advance the model by the same cycle, then clock.
  // A word for an msb pulse at cycle c appears on din_i at cycle c+LAT.
  task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] w,
                             input bit rdy, input bit clr, input bit rst);
    int s;
    bit al, pop, full, drop;
    msb_valid_i = v;
    m_ready_i   = rdy;
    clear_i     = clr;
    reset_i     = rst;
    if (v) din_by_cycle[cyc+LAT] = w;
    din_i = din_by_cycle.exists(cyc) ? din_by_cycle[cyc] : DATA_W'($urandom);
    hist[cyc] = v;
    if (rst) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_drops = 0;
      last_rst  = cyc;
    end else begin
      s    = cyc - LAT;
      al   = (s > last_rst) && hist.exists(s) && hist[s];
      pop  = (exp_q.size() > 0) && rdy;
      full = (exp_q.size() == DEPTH);
      drop = al && full && !pop;
      if (pop) popped_q.push_back(exp_q.pop_front());
      if (al && !drop) exp_q.push_back(din_i);
      if (clr) begin
        exp_ovf   = drop;
        exp_drops = drop ? 1 : 0;
      end else if (drop) begin
        exp_ovf = 1'b1;
        if (exp_drops < 255) exp_drops++;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    drive_cycle(0, '0, 0, 0, 1);
    drive_cycle(0, '0, 0, 0, 1);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", m_valid_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (m_data_o !== 6'h00) begin errors++; $display("FAIL reset_data got %0h want 0", m_data_o); end
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0b/%0d want 0/0", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_single();
    drive_cycle(0, '0, 1, 0, 0);
    drive_cycle(1, 6'h2B, 1, 0, 0);
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", m_valid_o); end
    drive_cycle(0, '0, 1, 0, 0);
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 6'h2B) begin errors++; $display("FAIL single_out got %0b/%0h want 1/2b", m_valid_o, m_data_o); end
    checks++; if (m_data_o !== exp_head()) begin errors++; $display("FAIL single_model got %0h want %0h", m_data_o, exp_head()); end
    drive_cycle(0, '0, 1, 0, 0);
    checks++; if (count_o !== 4'd0 || empty_o !== 1'b1) begin errors++; $display("FAIL single_pop count got %0d want 0", count_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 9; i++) begin
      drive_cycle(1, DATA_W'(i), 0, 0, 0);
      if (exp_valid()) begin
        checks++; if (m_data_o !== 6'h01) begin errors++; $display("FAIL fill_hold got %0h want 01", m_data_o); end
      end
    end
    drive_cycle(0, '0, 0, 0, 0);
    checks++; if (full_o !== 1'b1 || count_o !== 4'd8) begin errors++; $display("FAIL fill_full got %0b/%0d want 1/8", full_o, count_o); end
    checks++; if (m_data_o !== 6'h01) begin errors++; $display("FAIL fill_head got %0h want 01", m_data_o); end
    checks++; if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1) begin errors++; $display("FAIL fill_drop got %0b/%0d want 1/1", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] want [8];
    for (int i = 0; i < 7; i++) want[i] = DATA_W'(i + 2);
    want[7] = 6'h3F;
    drive_cycle(1, 6'h3F, 0, 0, 0);
    drive_cycle(0, '0, 1, 0, 0);
    checks++; if (count_o !== 4'd8 || full_o !== 1'b1) begin errors++; $display("FAIL pp_count got %0d want 8", count_o); end
    checks++; if (m_data_o !== 6'h02) begin errors++; $display("FAIL pp_head got %0h want 02", m_data_o); end
    checks++; if (drop_cnt_o !== 8'd1) begin errors++; $display("FAIL pp_nodrop got %0d want 1", drop_cnt_o); end
    popped_q.delete();
    for (int i = 0; i < 9; i++) begin
      checks++; if (m_valid_o !== exp_valid() || m_data_o !== exp_head()) begin errors++; $display("FAIL pp_drain got %0b/%0h want %0b/%0h", m_valid_o, m_data_o, exp_valid(), exp_head()); end
      drive_cycle(0, '0, 1, 0, 0);
    end
    checks++; if (popped_q.size() != 8) begin errors++; $display("FAIL pp_len got %0d want 8", popped_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (popped_q[i] !== want[i]) begin errors++; $display("FAIL pp_order[%0d] got %0h want %0h", i, popped_q[i], want[i]); end
      end
    end
    checks++; if (count_o !== 4'd0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL pp_empty got %0d want 0", count_o); end
  endtask

  task automatic test_saturate();
    drive_cycle(0, '0, 0, 1, 0);
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin errors++; $display("FAIL sat_pre got %0b/%0d want 0/0", overflow_o, drop_cnt_o); end
    for (int i = 0; i < 308; i++) drive_cycle(1, DATA_W'($urandom), 0, 0, 0);
    drive_cycle(0, '0, 0, 0, 0);
    checks++; if (drop_cnt_o !== 8'd255 || overflow_o !== 1'b1) begin errors++; $display("FAIL sat_cnt got %0d want 255", drop_cnt_o); end
    checks++; if (drop_cnt_o !== 8'(exp_drops)) begin errors++; $display("FAIL sat_model got %0d want %0d", drop_cnt_o, exp_drops); end
    drive_cycle(0, '0, 0, 1, 0);
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin errors++; $display("FAIL clr_plain got %0b/%0d want 0/0", overflow_o, drop_cnt_o); end
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL clr_keep got %0d want 8", count_o); end
    drive_cycle(1, 6'h15, 0, 0, 0);
    drive_cycle(0, '0, 0, 1, 0);
    checks++; if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1) begin errors++; $display("FAIL clr_drop got %0b/%0d want 1/1", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_stream();
    int idx, extra, it;
    bit tog, v;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive_cycle(0, '0, 1, 0, 0);
    drive_cycle(0, '0, 1, 1, 0);
    checks++; if (empty_o !== 1'b1 || overflow_o !== 1'b0) begin errors++; $display("FAIL stream_pre got %0b/%0b want 1/0", empty_o, overflow_o); end
    popped_q.delete();
    idx = 0; extra = 0; tog = 1'b1;
    for (it = 0; it < 600; it++) begin
      if (idx == 64) begin
        extra++;
        if (extra > LAT + 1 && exp_q.size() == 0) break;
      end
      v = (idx < 64) && (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
      drive_cycle(v, DATA_W'(idx), tog, 0, 0);
      if (v) idx++;
      tog = !tog;
      checks++; if (m_valid_o !== exp_valid() || m_data_o !== exp_head() || count_o !== 4'(exp_q.size())) begin errors++; $display("FAIL stream_cyc got %0b/%0h/%0d want %0b/%0h/%0d", m_valid_o, m_data_o, count_o, exp_valid(), exp_head(), exp_q.size()); end
    end
    checks++; if (it >= 600) begin errors++; $display("FAIL stream_timeout got %0d words want 64", idx); end
    checks++; if (popped_q.size() != 64) begin errors++; $display("FAIL stream_len got %0d want 64", popped_q.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        checks++; if (popped_q[i] !== DATA_W'(i)) begin errors++; $display("FAIL stream_order[%0d] got %0h want %0h", i, popped_q[i], i); end
      end
    end
    checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL stream_drops got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive_cycle(1, DATA_W'($urandom), 0, 0, 0);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL rmid_pre got %0d want 5", count_o); end
    drive_cycle(0, '0, 0, 0, 1);
    checks++; if (empty_o !== 1'b1 || m_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL rmid_clear got %0b/%0b/%0d want 1/0/0", empty_o, m_valid_o, count_o); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, '0, 1, 0, 0);
      checks++; if (m_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL rmid_ghost got %0b/%0d want 0/0", m_valid_o, count_o); end
    end
  endtask

  initial begin
    reset_i = 1'b1; msb_valid_i = 1'b0; din_i = '0; clear_i = 1'b0; m_ready_i = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_saturate();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_align_out_buffer.md
Name: time_align_out_buffer

Overview:
Downstream stage of the two-stage time aligner. It consumes the aligned 6-bit word {MSBs, LSBs} on the aligner's dout_o. It regenerates a sample-valid strobe matched to the aligner latency and buffers the words in a first-word-fall-through FIFO. Words leave toward the sink over a valid/ready handshake, and overflow drops are reported and counted.

Parameters:
DATA_W, 6, word width; equals aligner dout_o width ({msb[2:0], lsb[2:0]}).
DEPTH, 8, FIFO entries; power of 2, >= 2.
ALIGN_LAT, 1, cycles from msb_i presentation to a valid dout_o; legal range 0..4.
CNT_W, 8, drop counter width.

Ports:
clk_i  in  1  single clock, rising edge.
reset_i  in  1  synchronous, active-high reset.
msb_valid_i  in  1  high in the cycle a new msb_i sample is driven into the aligner.
din_i  in  DATA_W  aligner dout_o.
clear_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
m_valid_o  out  1  head word available.
m_ready_i  in  1  sink accepts the head word.
m_data_o  out  DATA_W  FIFO head word.
count_o  out  $clog2(DEPTH)+1  current occupancy.
full_o  out  1  count_o == DEPTH.
empty_o  out  1  count_o == 0.
overflow_o  out  1  sticky; a word was dropped.
drop_cnt_o  out  CNT_W  number of dropped words, saturating.

Behaviour:
- Reset: while reset_i=1 at a clock edge, all of the following are cleared:
  - the valid delay line, read/write pointers and count;
  - overflow_o and drop_cnt_o.
  - Resulting outputs: m_valid_o=0, empty_o=1, full_o=0, count_o=0, m_data_o=0.
  - Reset mid-operation discards all stored and in-flight words. No push occurs in the reset cycle.
- Valid alignment:
  - msb_valid_i passes through a delay line of ALIGN_LAT flops to produce aligned_vld.
  - ALIGN_LAT=0 means combinational pass-through.
  - din_i is sampled in cycles where aligned_vld=1.
- Push/pop:
  - push_req = aligned_vld.
  - pop = m_valid_o & m_ready_i.
  - push = push_req & (!full_o | pop).
- Simultaneous push and pop:
  - When full: accepted; count unchanged; the new word is written to the slot freed by the pop.
  - When empty: impossible, because m_valid_o=0.
- Output latency:
  - First-word-fall-through: m_valid_o = !empty_o, and m_data_o = mem[rd_ptr] with no read latency.
  - No bypass: a word pushed into an empty FIFO appears on m_valid_o/m_data_o in the following cycle.
  - Total latency is ALIGN_LAT+1 cycles from msb_valid_i to m_valid_o.
- Handshake rules:
  - m_data_o holds stable while m_valid_o=1 and m_ready_i=0.
  - m_ready_i is ignored when m_valid_o=0.
- Pointers: wrap modulo DEPTH. count_o updates by +1 (push only), -1 (pop only) or 0 (both or neither).
- Overflow:
  - Condition: push_req=1 & full_o=1 & pop=0. The word is dropped and FIFO contents are unchanged.
  - overflow_o is set to 1 the next cycle.
  - drop_cnt_o increments, saturating at 2^CNT_W-1 (255).
- Clear:
  - clear_i=1 sets overflow_o=0 and drop_cnt_o=0 next cycle.
  - If a drop occurs in the same cycle as clear_i, the drop is counted: overflow_o=1 and drop_cnt_o=1.
  - clear_i does not affect FIFO contents or pointers.
- Data path: no arithmetic; words are stored bit-exact. m_data_o[5:3] carries the MSBs and m_data_o[2:0] carries the LSBs.

Test Plan:
- Reset, then msb_valid_i pulse with ALIGN_LAT=1 and din_i=6'h2B in the following cycle, m_ready_i=1 -> m_valid_o=1 with m_data_o=6'h2B two cycles after the pulse; count_o returns to 0 after the pop.
- m_ready_i=0; push 8 words 6'h01..6'h08 -> full_o=1, count_o=8, m_data_o=6'h01 held stable; 9th word 6'h09 -> overflow_o=1, drop_cnt_o=1, and 6'h09 is never output.
- Full FIFO; push 6'h3F while m_ready_i=1 in the same cycle -> 6'h01 popped, count_o stays 8, and 6'h3F is output last after 6'h02..6'h08.
- Drop 300 words while m_ready_i=0 -> drop_cnt_o saturates at 255. Then clear_i=1 with no drop in that cycle -> overflow_o=0, drop_cnt_o=0. Then clear_i=1 together with a drop -> overflow_o=1, drop_cnt_o=1.
- Continuous stream 6'h00..6'h3F with m_ready_i toggling 1,0,1,0 -> output order is exact; wrap-around of both pointers is exercised at least 4 times.
- Assert reset_i with count_o=5 and a valid in the delay line -> next cycle empty_o=1, m_valid_o=0, count_o=0; the in-flight word does not appear after reset.
